// File: rtl/sram_stream_ctrl.sv
// Streaming initiator for the single-port message SRAM: FILL turns a valid/ready
// stream into sequential writes, DRAIN turns sequential reads into a backpressured stream.
module sram_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [AW-1:0]    i_base,
  input  logic [AW-1:0]    i_len,
  output logic             o_busy,
  output logic             o_done,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ready,
  output logic             o_wen,
  output logic [AW-1:0]    o_waddr,
  output logic [AW-1:0]    o_raddr,
  output logic [WIDTH-1:0] o_wdata,
  input  logic [WIDTH-1:0] i_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  function automatic logic [AW-1:0] eff_len(input logic [AW-1:0] len);
    return (len > DEPTH_A) ? DEPTH_A : len;
  endfunction

  state_e           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    len_q, len_d;
  logic [AW-1:0]    req_cnt_q, req_cnt_d;
  logic [AW-1:0]    pop_cnt_q, pop_cnt_d;
  logic             wen_q, wen_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rd_addr_q, rd_addr_d;
  logic             rd_data_q, rd_data_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [WIDTH-1:0] fifo_q [2];
  logic [WIDTH-1:0] fifo_d [2];

  logic [AW-1:0]    start_len;
  logic [1:0]       fifo_after;
  logic             in_ready, fill_hs, out_valid, pop, push;
  logic             start_drain, issue_drain;

  // rd_addr_q: an address sits on o_raddr not yet sampled by the SRAM.
  // rd_data_q: i_rdata carries a word not yet pushed. While o_raddr is held,
  // the SRAM re-reads the same entry, so an unpushed word stays on the bus.
  always_comb begin
    start_len   = eff_len(i_len);
    in_ready    = (state_q == S_FILL) && (req_cnt_q < len_q);
    fill_hs     = in_ready && i_in_valid;
    out_valid   = (state_q == S_DRAIN) && (fifo_cnt_q != 2'd0);
    pop         = out_valid && i_out_ready;
    push        = rd_data_q && ((fifo_cnt_q != 2'd2) || pop);
    fifo_after  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    start_drain = (state_q == S_IDLE) && i_start && i_mode && (start_len != '0);
    issue_drain = (state_q == S_DRAIN) && (req_cnt_q < len_q) && (fifo_after < 2'd2);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (start_len == '0) state_d = S_DONE;
          else if (i_mode)     state_d = S_DRAIN;
          else                 state_d = S_FILL;
        end
      end
      S_FILL:  if (req_cnt_q == len_q) state_d = S_DONE;
      S_DRAIN: if (pop && (pop_cnt_q == len_q - AW'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    raddr_d    = raddr_q;
    rd_addr_d  = 1'b0;
    rd_data_d  = rd_addr_q | (rd_data_q & ~push);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_after;
    fifo_d     = fifo_q;

    if ((state_q == S_IDLE) && i_start) begin
      base_d    = i_base;
      len_d     = start_len;
      req_cnt_d = '0;
      pop_cnt_d = '0;
    end
    // The first read goes out on the start edge so data reaches the stream two cycles later.
    if (start_drain) begin
      raddr_d   = i_base;
      req_cnt_d = AW'(1);
      rd_addr_d = 1'b1;
    end
    if (fill_hs) begin
      wen_d     = 1'b1;
      waddr_d   = base_q + req_cnt_q;
      wdata_d   = i_in_data;
      req_cnt_d = req_cnt_q + AW'(1);
    end
    if (issue_drain) begin
      raddr_d   = base_q + req_cnt_q;
      req_cnt_d = req_cnt_q + AW'(1);
      rd_addr_d = 1'b1;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = i_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      pop_cnt_d = pop_cnt_q + AW'(1);
    end
  end

  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_done      = (state_q == S_DONE);
    o_in_ready  = in_ready;
    o_out_valid = out_valid;
    o_out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
    o_wen       = wen_q;
    o_waddr     = waddr_q;
    o_raddr     = raddr_q;
    o_wdata     = wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      req_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wdata_q    <= '0;
      rd_addr_q  <= 1'b0;
      rd_data_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      wdata_q    <= wdata_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl: per-cycle vector table plus hand sequences
// for backpressure, address wrap, ignored restart and mid-command reset.
module tb_sram_stream_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_mode;
  logic [AW-1:0]    i_base, i_len;
  logic             o_busy, o_done;
  logic             i_in_valid;
  logic [WIDTH-1:0] i_in_data;
  logic             o_in_ready, o_out_valid;
  logic [WIDTH-1:0] o_out_data;
  logic             i_out_ready;
  logic             o_wen;
  logic [AW-1:0]    o_waddr, o_raddr;
  logic [WIDTH-1:0] o_wdata;
  logic [WIDTH-1:0] i_rdata = '0;

  sram_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_base(i_base),
    .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .i_in_valid(i_in_valid),
    .i_in_data(i_in_data), .o_in_ready(o_in_ready), .o_out_valid(o_out_valid),
    .o_out_data(o_out_data), .i_out_ready(i_out_ready), .o_wen(o_wen),
    .o_waddr(o_waddr), .o_raddr(o_raddr), .o_wdata(o_wdata), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: one write port, registered read only when not writing.
  logic [WIDTH-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (o_wen) mem[o_waddr[9:0]] <= o_wdata;
    else       i_rdata <= mem[o_raddr[9:0]];
  end

  logic [AW-1:0]    wa_q [$];
  logic [WIDTH-1:0] wd_q [$];
  always @(posedge clk) begin
    #1;
    if (o_wen) begin
      wa_q.push_back(o_waddr);
      wd_q.push_back(o_wdata);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             start, mode;
    logic [AW-1:0]    base, len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             e_busy, e_done, e_in_ready, e_wen;
    logic [AW-1:0]    e_waddr;
    logic [WIDTH-1:0] e_wdata;
    logic             e_out_valid;
    logic [WIDTH-1:0] e_out_data;
    logic             chk_ra;
    logic [AW-1:0]    e_raddr;
  } vec_t;

  function automatic vec_t v(input logic st, input logic md, input logic [AW-1:0] b,
                             input logic [AW-1:0] l, input logic iv, input logic [WIDTH-1:0] id,
                             input logic ordy, input logic eb, input logic ed, input logic eir,
                             input logic ew, input logic [AW-1:0] ewa, input logic [WIDTH-1:0] ewd,
                             input logic eov, input logic [WIDTH-1:0] eod, input logic cra,
                             input logic [AW-1:0] era);
    vec_t r;
    r.start = st; r.mode = md; r.base = b; r.len = l; r.in_valid = iv; r.in_data = id;
    r.out_ready = ordy; r.e_busy = eb; r.e_done = ed; r.e_in_ready = eir; r.e_wen = ew;
    r.e_waddr = ewa; r.e_wdata = ewd; r.e_out_valid = eov; r.e_out_data = eod;
    r.chk_ra = cra; r.e_raddr = era;
    return r;
  endfunction

  task automatic run_fill(input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input logic [WIDTH-1:0] d0, input bit glitch, input string tag);
    int k;
    int done_c;
    k = 0;
    done_c = -1;
    @(negedge clk);
    i_start = 1'b1; i_mode = 1'b0; i_base = base; i_len = len; i_in_valid = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_done) begin
        done_c = c;
        break;
      end
      i_start    = glitch && (c == 1);
      i_mode     = 1'b1;
      i_base     = 20'h00050;
      i_len      = 20'd5;
      i_in_valid = (k < int'(len));
      i_in_data  = 8'(d0 + 8'(k));
      if (i_in_valid && o_in_ready) k++;
      @(negedge clk);
    end
    i_start = 1'b0;
    i_in_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_c >= 0), 32'd1);
    chk({tag, "_accepted"}, 32'(k), 32'(len));
    chk({tag, "_done_cycle"}, 32'(done_c), 32'(int'(len) + 1));
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_drain(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [WIDTH-1:0] d0, input bit rnd, input string tag);
    int got, issued, first_c, last_c, done_c;
    logic [AW-1:0] prev_ra;
    logic rdy;
    got = 0; issued = 0; first_c = -1; last_c = -1; done_c = -1;
    @(negedge clk);
    prev_ra = o_raddr;
    i_start = 1'b1; i_mode = 1'b1; i_base = base; i_len = len; i_out_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (o_done) begin
        done_c = c;
        break;
      end
      if (o_raddr != prev_ra) begin
        issued++;
        prev_ra = o_raddr;
      end
      chk({tag, "_outstanding_le3"}, 32'((issued - got) <= 3), 32'd1);
      if (!rnd)      rdy = 1'b1;
      else if (c < 4) rdy = (c == 0) || (c == 3);
      else           rdy = 1'($urandom_range(0, 1));
      i_out_ready = rdy;
      if (o_out_valid && first_c < 0) first_c = c;
      if (o_out_valid && rdy) begin
        chk($sformatf("%s_data%0d", tag, got), 32'(o_out_data), 32'(8'(d0 + 8'(got))));
        got++;
        last_c = c;
      end
      @(negedge clk);
    end
    i_out_ready = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_c >= 0), 32'd1);
    chk({tag, "_word_count"}, 32'(got), 32'(len));
    chk({tag, "_read_count"}, 32'(issued), 32'(len));
    chk({tag, "_done_after_last"}, 32'(done_c), 32'(last_c + 1));
    if (!rnd) begin
      chk({tag, "_first_valid"}, 32'(first_c), 32'd2);
      chk({tag, "_back_to_back"}, 32'(last_c), 32'(first_c + int'(len) - 1));
    end
  endtask

  vec_t tbl [$];
  vec_t r;

  initial begin
    rst = 1'b1;
    i_start = 1'b0; i_mode = 1'b0; i_base = '0; i_len = '0;
    i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_data", 32'(o_out_data), 32'd0);
    chk("rst_wen", 32'(o_wen), 32'd0);
    chk("rst_waddr", 32'(o_waddr), 32'd0);
    chk("rst_raddr", 32'(o_raddr), 32'd0);
    chk("rst_wdata", 32'(o_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // FILL base=5 L=4
    tbl.push_back(v(1, 0, 5, 4, 0, 'h00, 0,  1, 0, 1, 0, 0, 'h00, 0, 'h00, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 'h11, 0,  1, 0, 1, 1, 5, 'h11, 0, 'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 'h22, 0,  1, 0, 1, 1, 6, 'h22, 0, 'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 'h33, 0,  1, 0, 1, 1, 7, 'h33, 0, 'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 'h44, 0,  1, 0, 0, 1, 8, 'h44, 0, 'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 0,  1, 1, 0, 0, 0, 'h00, 0, 'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00, 0, 0));
    // DRAIN base=5 L=4, always ready
    tbl.push_back(v(1, 1, 5, 4, 0, 'h00, 1,  1, 0, 0, 0, 0, 'h00, 0, 'h00, 1, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 1,  1, 0, 0, 0, 0, 'h00, 0, 'h00, 1, 6));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 1,  1, 0, 0, 0, 0, 'h00, 1, 'h11, 1, 7));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 1,  1, 0, 0, 0, 0, 'h00, 1, 'h22, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 1,  1, 0, 0, 0, 0, 'h00, 1, 'h33, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 1,  1, 0, 0, 0, 0, 'h00, 1, 'h44, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 1,  1, 1, 0, 0, 0, 'h00, 0, 'h00, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00, 1, 8));
    // zero length, FILL then DRAIN: done right away, no write, no read
    tbl.push_back(v(1, 0, 'h100, 0, 1, 'h55, 0,  1, 1, 0, 0, 0, 'h00, 0, 'h00, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00, 1, 8));
    tbl.push_back(v(1, 1, 'h100, 0, 0, 'h00, 1,  1, 1, 0, 0, 0, 'h00, 0, 'h00, 1, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 'h00, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00, 1, 8));

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      @(negedge clk);
      i_start = r.start; i_mode = r.mode; i_base = r.base; i_len = r.len;
      i_in_valid = r.in_valid; i_in_data = r.in_data; i_out_ready = r.out_ready;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_busy", i), 32'(o_busy), 32'(r.e_busy));
      chk($sformatf("row%0d_done", i), 32'(o_done), 32'(r.e_done));
      chk($sformatf("row%0d_in_ready", i), 32'(o_in_ready), 32'(r.e_in_ready));
      chk($sformatf("row%0d_wen", i), 32'(o_wen), 32'(r.e_wen));
      chk($sformatf("row%0d_out_valid", i), 32'(o_out_valid), 32'(r.e_out_valid));
      if (r.e_wen) begin
        chk($sformatf("row%0d_waddr", i), 32'(o_waddr), 32'(r.e_waddr));
        chk($sformatf("row%0d_wdata", i), 32'(o_wdata), 32'(r.e_wdata));
      end
      if (r.e_out_valid) chk($sformatf("row%0d_out_data", i), 32'(o_out_data), 32'(r.e_out_data));
      if (r.chk_ra) chk($sformatf("row%0d_raddr", i), 32'(o_raddr), 32'(r.e_raddr));
    end
    i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;

    // Preload 16..23, then drain under random backpressure
    wa_q.delete(); wd_q.delete();
    run_fill(20'd16, 20'd8, 8'hA0, 1'b0, "fill16");
    chk("fill16_nwrites", 32'(wa_q.size()), 32'd8);
    for (int i = 0; i < wa_q.size() && i < 8; i++) begin
      chk($sformatf("fill16_waddr%0d", i), 32'(wa_q[i]), 32'(16 + i));
      chk($sformatf("fill16_wdata%0d", i), 32'(wd_q[i]), 32'(8'hA0 + 8'(i)));
    end
    wa_q.delete(); wd_q.delete();
    run_drain(20'd16, 20'd8, 8'hA0, 1'b1, "drain_bp");
    chk("drain_bp_no_wen", 32'(wa_q.size()), 32'd0);

    // Wrapping FILL with a start pulse while busy, then read the block back
    wa_q.delete(); wd_q.delete();
    run_fill(20'hFFFFE, 20'd3, 8'hC0, 1'b1, "fill_wrap");
    chk("wrap_nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      chk("wrap_waddr0", 32'(wa_q[0]), 32'h000FFFFE);
      chk("wrap_waddr1", 32'(wa_q[1]), 32'h000FFFFF);
      chk("wrap_waddr2", 32'(wa_q[2]), 32'h00000000);
      chk("wrap_wdata2", 32'(wd_q[2]), 32'h000000C2);
    end
    run_drain(20'hFFFFE, 20'd3, 8'hC0, 1'b0, "drain_wrap");

    // Reset in the middle of a DRAIN, then a fresh command
    @(negedge clk);
    i_start = 1'b1; i_mode = 1'b1; i_base = 20'd16; i_len = 20'd6; i_out_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_valid", 32'(o_out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_out_valid", 32'(o_out_valid), 32'd0);
    chk("abort_out_data", 32'(o_out_data), 32'd0);
    chk("abort_wen", 32'(o_wen), 32'd0);
    chk("abort_raddr", 32'(o_raddr), 32'd0);
    chk("abort_in_ready", 32'(o_in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    i_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone%0d", c), 32'({o_busy, o_done}), 32'd0);
    end
    run_drain(20'd16, 20'd6, 8'hA0, 1'b0, "drain_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
